enc_gray_arb: RTL and testbench
===============================

ENC_GRAY_ARB -- requirements
Module: enc_gray_arb

Interface
REQ-001 The block SHALL have one parameter: NREQ, default 4, the number of requesters sharing the converter (fixed at 4 in this revision).
REQ-002 Ports SHALL be:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  4  requester i offers a word when bit i is high
- req_bin  input  40  requester i binary word on bits [10i+9:10i]
- req_ready  output  4  requester i word accepted this cycle when bit i is high
- out_valid  output  1  out_gray/out_id hold a result
- out_ready  input  1  consumer takes the result this cycle when high with out_valid
- out_gray  output  10  Gray code of the accepted word
- out_id  output  2  index of the requester that produced out_gray
- conv_count  output  16  count of completed output transfers
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 The block SHALL apply exactly one 10-bit binary-to-Gray conversion per accepted word: gray[9] = bin[9]; gray[k] = bin[k+1] XOR bin[k] for k = 0..8.
REQ-005 Stage-free condition: free = !out_valid OR out_ready.
REQ-006 When free and any req_valid bit is set, the block SHALL grant exactly one requester, chosen round-robin.
REQ-007 Round-robin search SHALL start at index (last_grant+1) mod 4 and proceed upward with wrap-around; the first requester with valid high wins.
REQ-008 req_ready SHALL be combinational: it is one-hot at the granted index when a grant occurs, and all-zero otherwise (no valid requests, or not free).
REQ-009 A requester's word SHALL be accepted only on a cycle where both its req_valid and its req_ready are high.
REQ-010 On acceptance, the output register SHALL load out_gray = Gray(req_bin of winner) and out_id = winner, set out_valid = 1, and update last_grant = winner, all at the next rising edge. Latency from acceptance to out_valid is one cycle.
REQ-011 On an output transfer (out_valid AND out_ready) with no new grant, out_valid SHALL clear at the next edge; out_gray and out_id SHALL hold their last values.
REQ-012 On an output transfer with a simultaneous grant, the register SHALL load the new result with no bubble, sustaining one word per cycle.
REQ-013 While out_valid = 1 and out_ready = 0, out_gray, out_id and out_valid SHALL remain stable and req_ready SHALL be 0.
REQ-014 last_grant SHALL change only on a grant. A requester that deasserts valid before being granted SHALL lose nothing, and SHALL not block the others.
REQ-015 conv_count SHALL increment by 1 at each output transfer and SHALL saturate at 16'hFFFF (no wrap).
REQ-016 With all four requesters continuously valid and out_ready held at 1, grants SHALL rotate 0,1,2,3,0,... Each requester SHALL wait at most 3 grants between its own grants.

Reset
REQ-017 While rst_n = 0 (asserted asynchronously, including mid-transfer), the block SHALL hold out_valid = 0, out_gray = 0, out_id = 0, conv_count = 0, and last_grant = 3, so that requester 0 has priority first.
REQ-018 req_ready SHALL be 0 while rst_n = 0. Any pending result SHALL be discarded and not counted.
REQ-019 After rst_n deasserts, operation SHALL begin on the first rising edge with no extra idle cycles required.

Verification
REQ-020 Single requester: after reset, req_valid = 4'b0100 with word 2 = 10'h3FF and out_ready = 1 -> req_ready = 4'b0100. The next cycle shows out_valid = 1, out_gray = 10'h200, out_id = 2, and conv_count becomes 1 after the transfer.
REQ-021 Full contention: all valid, words 10'h001/10'h002/10'h155/10'h2AA, out_ready = 1 -> out_id sequence 0,1,2,3,0 with out_gray 10'h001, 10'h003, 10'h1FF, 10'h3FF.
REQ-022 Backpressure: out_ready = 0 for 5 cycles while valid pending -> req_ready = 0 and outputs stable. After out_ready = 1, the next word appears one cycle later with no loss or duplication.
REQ-023 Reset mid-operation: assert rst_n = 0 while out_valid = 1 -> out_valid, out_gray and conv_count go to 0 immediately. After release with req_valid = 4'b1111, requester 0 is granted first.
REQ-024 Saturation: preload conv_count toward the limit via 65 540 transfers -> conv_count stops at 16'hFFFF.
REQ-025 Exhaustive check: all 1024 inputs through requester 3 -> each out_gray equals bin ^ (bin >> 1), and adjacent inputs differ in exactly one out_gray bit.

Source files
------------

// File: rtl/enc_gray_arb.sv
// enc_gray_arb: round-robin arbiter feeding a single binary-to-Gray converter.
// Up to four requesters compete for one output register; the winner's 10-bit
// word is converted once and held with its requester index until the consumer
// takes it. A saturating counter tallies completed output transfers.
module enc_gray_arb #(
  parameter int NREQ = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*10-1:0] req_bin,
  output logic [NREQ-1:0]  req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       out_gray,
  output logic [1:0]       out_id,
  output logic [15:0]      conv_count
);

  logic [NREQ-1:0][9:0] lanes;
  logic [1:0]           last_grant;
  logic [1:0]           grant_idx;
  logic                 found;
  logic                 free;
  logic                 grant;
  logic                 xfer;
  logic [9:0]           win_bin;
  logic [9:0]           win_gray;

  assign lanes = req_bin;

  // Search upward from the requester after the last winner, wrapping around.
  always_comb begin
    logic [1:0] idx;
    idx       = '0;
    found     = 1'b0;
    grant_idx = last_grant;
    for (int k = 1; k <= NREQ; k++) begin
      idx = last_grant + 2'(k);
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // The stage takes a new word when empty or being drained this cycle;
  // reset gates the grant so nothing is offered while the block is held.
  assign free      = !out_valid || out_ready;
  assign grant     = rst_n && free && found;
  assign xfer      = out_valid && out_ready;
  assign req_ready = grant ? (NREQ'(1) << grant_idx) : '0;

  // Only the winning word is converted.
  assign win_bin  = lanes[grant_idx];
  assign win_gray = {win_bin[9], win_bin[9:1] ^ win_bin[8:0]};

  // Output register and arbitration pointer; last_grant starts at 3 so
  // requester 0 is first in line after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_gray   <= '0;
      out_id     <= '0;
      last_grant <= 2'd3;
    end else if (grant) begin
      out_valid  <= 1'b1;
      out_gray   <= win_gray;
      out_id     <= grant_idx;
      last_grant <= grant_idx;
    end else if (xfer) begin
      out_valid  <= 1'b0;
    end
  end

  // Count completed transfers, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      conv_count <= '0;
    else if (xfer && conv_count != 16'hFFFF)
      conv_count <= conv_count + 16'd1;
  end

endmodule

// File: tb/tb_enc_gray_arb.sv
// Bench for enc_gray_arb: directed phases drive requests; every accepted word
// is queued with its expected requester/word, and a negedge monitor checks
// each output transfer against the head of the queue.
module tb_enc_gray_arb;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      req_valid = '0;
  logic [3:0][9:0] words = '0;
  logic [39:0]     req_bin;
  logic [3:0]      req_ready;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [9:0]      out_gray;
  logic [1:0]      out_id;
  logic [15:0]     conv_count;

  assign req_bin = words;

  enc_gray_arb #(.NREQ(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_bin    (req_bin),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_gray   (out_gray),
    .out_id     (out_id),
    .conv_count (conv_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [9:0] bin;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // reference model state
  logic       m_vld = 1'b0;
  logic [1:0] m_last = 2'd3;
  int         m_cnt = 0;

  // exhaustive-phase adjacency tracking
  logic       exh = 1'b0;
  logic       have_prev = 1'b0;
  logic [9:0] prev_bin = '0;
  logic [9:0] prev_gray = '0;
  exp_t       mon_e;

  function automatic logic [9:0] gray(input logic [9:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: check handshake/state at negedge, update model, run the edge.
  task automatic step();
    logic       free;
    logic [3:0] exp_rdy;
    logic [1:0] idx;
    logic [1:0] w;
    @(negedge clk);
    free    = !m_vld || out_ready;
    exp_rdy = '0;
    w       = '0;
    if (free) begin
      for (int k = 1; k <= 4; k++) begin
        idx = m_last + 2'(k);
        if (req_valid[idx] && exp_rdy == 4'b0) begin
          exp_rdy[idx] = 1'b1;
          w = idx;
        end
      end
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    chk("conv_count", 32'(conv_count), 32'(m_cnt));
    if (m_vld && out_ready && m_cnt < 65535) m_cnt++;
    if (exp_rdy != 4'b0) begin
      q.push_back('{id: w, bin: words[w]});
      m_last = w;
      m_vld  = 1'b1;
    end else if (m_vld && out_ready) begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, check the cleared state, release after an edge.
  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_gray", 32'(out_gray), 0);
    chk("rst_out_id", 32'(out_id), 0);
    chk("rst_conv_count", 32'(conv_count), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    q.delete();
    m_vld  = 1'b0;
    m_last = 2'd3;
    m_cnt  = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: every output transfer must match the oldest accepted word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual id=%0d gray=%0h expected none", out_id, out_gray);
      end else begin
        mon_e = q.pop_front();
        chk("sb_out_id", 32'(out_id), 32'(mon_e.id));
        chk("sb_out_gray", 32'(out_gray), 32'(gray(mon_e.bin)));
        if (exh && mon_e.id == 2'd3) begin
          if (have_prev && mon_e.bin == prev_bin + 10'd1)
            chk("gray_adjacent", 32'($countones(out_gray ^ prev_gray)), 1);
          have_prev = 1'b1;
          prev_bin  = mon_e.bin;
          prev_gray = out_gray;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ids[5];
    logic [9:0] gs[5];
    ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    gs  = '{10'h001, 10'h003, 10'h1FF, 10'h3FF, 10'h001};

    // reset state
    req_valid = 4'b0100;
    #12;
    chk("init_out_valid", 32'(out_valid), 0);
    chk("init_conv_count", 32'(conv_count), 0);
    chk("init_req_ready", 32'(req_ready), 0);
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single requester
    words[2] = 10'h3FF; req_valid = 4'b0100; out_ready = 1'b1;
    step();
    chk("single_out_valid", 32'(out_valid), 1);
    chk("single_out_gray", 32'(out_gray), 32'h200);
    chk("single_out_id", 32'(out_id), 2);
    req_valid = '0;
    step();
    chk("single_count", 32'(conv_count), 1);

    // full contention from reset
    do_reset();
    words = {10'h2AA, 10'h155, 10'h002, 10'h001};
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_out_id", 32'(out_id), 32'(ids[i]));
      chk("rr_out_gray", 32'(out_gray), 32'(gs[i]));
    end
    req_valid = '0;
    step(); step();

    // backpressure
    words[1] = 10'h0F0; req_valid = 4'b0010;
    step();
    out_ready = 1'b0; req_valid = 4'b0011; words[0] = 10'h155;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_gray", 32'(out_gray), 32'h088);
      chk("bp_out_id", 32'(out_id), 1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_next_id", 32'(out_id), 0);
    chk("bp_next_gray", 32'(out_gray), 32'h1FF);
    req_valid = '0;
    step(); step();

    // reset while holding a result
    req_valid = 4'b0010; out_ready = 1'b0;
    step();
    chk("pre_rst_valid", 32'(out_valid), 1);
    do_reset();
    req_valid = 4'b1111; out_ready = 1'b1;
    step();
    chk("post_rst_id", 32'(out_id), 0);
    req_valid = '0;
    step(); step();

    // exhaustive through requester 3
    exh = 1'b1;
    req_valid = 4'b1000;
    for (int b = 0; b < 1024; b++) begin
      words[3] = 10'(b);
      step();
    end
    req_valid = '0;
    step(); step();
    exh = 1'b0;

    // saturation
    do_reset();
    req_valid = 4'b0001; out_ready = 1'b1; words[0] = 10'h123;
    for (int i = 0; i < 65540; i++) step();
    req_valid = '0;
    step(); step();
    chk("sat_count", 32'(conv_count), 32'hFFFF);

    chk("queue_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
